// File: rtl/ebus_xfer_ctl_if.sv
// EBUS-side signal bundle for the I/O transfer sequencer.
// master = EBOX sequencer, slave = arbiter/device/data-mux side.
interface ebus_xfer_ctl_if;
  logic        ebusGrant;
  logic        ebusXfer;
  logic [0:35] ebusDataIn;
  logic        ebusReq;
  logic [0:6]  ebusCS;
  logic [0:2]  ebusFCN;
  logic        ebusDemand;
  logic        drvDriving;
  logic [0:35] drvData;

  modport master (
    input  ebusGrant, ebusXfer, ebusDataIn,
    output ebusReq, ebusCS, ebusFCN, ebusDemand,
    output drvDriving, drvData
  );

  modport slave (
    output ebusGrant, ebusXfer, ebusDataIn,
    input  ebusReq, ebusCS, ebusFCN, ebusDemand,
    input  drvDriving, drvData
  );
endinterface

// File: rtl/ebus_xfer_ctl.sv
// EBOX-side EBUS transfer sequencer for CONO/CONI/DATAO/DATAI.
// Request, setup, demand/xfer handshake, release, one-cycle done.
module ebus_xfer_ctl #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        start,
  input  logic        isRead,
  input  logic [0:6]  cs,
  input  logic [0:2]  fcn,
  input  logic [0:35] wdata,
  ebus_xfer_ctl_if.master bus,
  output logic        ready,
  output logic        done,
  output logic        nxm,
  output logic [0:35] rdata
);

  typedef enum logic [2:0] {
    IDLE, REQ, SETUP, DEMAND, RELEASE, DONE
  } state_e;

  localparam logic [CNT_W-1:0] SetupLast =
    CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ToLast =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic [0:6]        cs_q, cs_d;
  logic [0:2]        fcn_q, fcn_d;
  logic [0:35]       wdata_q, wdata_d;
  logic [0:35]       rdata_q, rdata_d;
  logic              nxm_q, nxm_d;

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      cs_q    <= '0;
      fcn_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      nxm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      cs_q    <= cs_d;
      fcn_q   <= fcn_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nxm_q   <= nxm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    cs_d    = cs_q;
    fcn_d   = fcn_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nxm_d   = nxm_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_d    = isRead;
          cs_d    = cs;
          fcn_d   = fcn;
          wdata_d = wdata;
          nxm_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.ebusGrant) begin
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = DEMAND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DEMAND: begin
        // A transfer in the final timeout cycle still counts as a success
        if (bus.ebusXfer) begin
          if (rd_q) rdata_d = bus.ebusDataIn;
          nxm_d   = 1'b0;
          state_d = RELEASE;
        end else if (cnt_q == ToLast) begin
          if (rd_q) rdata_d = '0;
          nxm_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!bus.ebusXfer) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic own_bus, drive_win;

  assign own_bus   = (state_q == SETUP) ||
                     (state_q == DEMAND) ||
                     (state_q == RELEASE);
  assign drive_win = ((state_q == SETUP) ||
                      (state_q == DEMAND)) && !rd_q;

  assign bus.ebusReq    = own_bus || (state_q == REQ);
  assign bus.ebusCS     = own_bus ? cs_q : '0;
  assign bus.ebusFCN    = own_bus ? fcn_q : '0;
  assign bus.ebusDemand = (state_q == DEMAND);
  assign bus.drvDriving = drive_win;
  assign bus.drvData    = drive_win ? wdata_q : '0;

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign nxm   = nxm_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_ebus_xfer_ctl.sv
// Directed self-checking bench for ebus_xfer_ctl.
// Device/arbiter behaviour is scripted per transfer by run().
module tb_ebus_xfer_ctl;

  logic        clk = 1'b0;
  logic        CROBAR;
  logic        start;
  logic        isRead;
  logic [0:6]  cs;
  logic [0:2]  fcn;
  logic [0:35] wdata;
  logic        ready, done, nxm;
  logic [0:35] rdata;

  int ncmp = 0;
  int nerr = 0;

  int          r_dem, r_rel, r_done, r_bad;
  int          r_reqonly, r_gap;
  bit          r_drv, r_nxm, r_nxm0;
  logic [0:35] r_rdata;

  ebus_xfer_ctl_if ebus ();

  ebus_xfer_ctl dut (
    .clk    (clk),
    .CROBAR (CROBAR),
    .start  (start),
    .isRead (isRead),
    .cs     (cs),
    .fcn    (fcn),
    .wdata  (wdata),
    .bus    (ebus),
    .ready  (ready),
    .done   (done),
    .nxm    (nxm),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkb(input string tag,
                      input logic obs,
                      input logic exp_);
    ncmp++;
    assert (obs === exp_) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp_);
    end
  endtask

  task automatic chki(input string tag,
                      input int obs,
                      input int exp_);
    ncmp++;
    assert (obs === exp_) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp_);
    end
  endtask

  task automatic chkd(input string tag,
                      input logic [0:35] obs,
                      input logic [0:35] exp_);
    ncmp++;
    assert (obs === exp_) else begin
      nerr++;
      $error("FAIL %s: observed %o expected %o",
             tag, obs, exp_);
    end
  endtask

  // gd: grant withheld for gd REQ cycles; xat: DEMAND cycle (1-based)
  // in which xfer rises (-1 = never); hold: cycles xfer stays high.
  task automatic run(input bit          rd,
                     input logic [0:6]  c,
                     input logic [0:2]  f,
                     input logic [0:35] wd,
                     input int          gd,
                     input int          xat,
                     input int          hold,
                     input logic [0:35] din);
    int cyc = 0;
    int xl  = 0;
    start  = 1'b1;
    isRead = rd;
    cs     = c;
    fcn    = f;
    wdata  = wd;
    tick();
    start     = 1'b0;
    r_dem     = 0;
    r_rel     = 0;
    r_bad     = 0;
    r_reqonly = 0;
    r_gap     = 0;
    r_drv     = 1'b0;
    r_done    = -1;
    r_nxm     = 1'b0;
    r_rdata   = '0;
    r_nxm0    = nxm;
    while (cyc < 300 && r_done < 0) begin
      if (done) begin
        r_done  = cyc;
        r_nxm   = nxm;
        r_rdata = rdata;
      end else begin
        if (ebus.ebusDemand) r_dem++;
        if (ebus.ebusReq && !ebus.ebusDemand && r_dem > 0)
          r_rel++;
        if (ebus.ebusReq && ebus.ebusCS == '0) r_reqonly++;
        if (!ebus.ebusReq) r_gap++;
        if (ebus.drvDriving) r_drv = 1'b1;
        if (ebus.drvDriving ? (ebus.drvData !== wd)
                            : (ebus.drvData !== '0))
          r_bad++;
        if (ebus.ebusDemand && r_dem == xat) xl = hold;
        ebus.ebusXfer   = (xl > 0);
        ebus.ebusDataIn = (xl > 0) ? din : 36'o111;
        if (xl > 0) xl--;
        ebus.ebusGrant = (cyc >= gd);
        cyc++;
        tick();
      end
    end
    ebus.ebusXfer = 1'b0;
    tick();
  endtask

  initial begin
    CROBAR          = 1'b1;
    start           = 1'b0;
    isRead          = 1'b0;
    cs              = '0;
    fcn             = '0;
    wdata           = '0;
    ebus.ebusGrant  = 1'b0;
    ebus.ebusXfer   = 1'b0;
    ebus.ebusDataIn = '0;
    tick();
    tick();
    chkb("rst_ready", ready, 1'b1);
    chkb("rst_req", ebus.ebusReq, 1'b0);
    chki("rst_cs_fcn", int'({ebus.ebusCS, ebus.ebusFCN}), 0);
    chkb("rst_demand", ebus.ebusDemand, 1'b0);
    chkb("rst_drv", ebus.drvDriving, 1'b0);
    chkd("rst_drvdata", ebus.drvData, '0);
    chkb("rst_done_nxm", done | nxm, 1'b0);
    chkd("rst_rdata", rdata, '0);
    CROBAR = 1'b0;
    tick();

    // Write, xfer in 2nd DEMAND cycle
    run(1'b0, 7'o24, 3'o4, 36'o123456701234, 0, 2, 1, 36'o0);
    chki("wr_done_cyc", r_done, 6);
    chki("wr_demand_cycles", r_dem, 2);
    chkb("wr_drv_seen", r_drv, 1'b1);
    chki("wr_drvdata_bad", r_bad, 0);
    chkb("wr_nxm", r_nxm, 1'b0);
    chki("wr_release", r_rel, 1);
    chkb("wr_ready_after", ready, 1'b1);

    // Read, xfer in 1st DEMAND cycle
    run(1'b1, 7'o13, 3'o2, 36'o0, 0, 1, 1, 36'o777000000001);
    chki("rd_done_cyc", r_done, 5);
    chkb("rd_drv_never", r_drv, 1'b0);
    chki("rd_drvdata_bad", r_bad, 0);
    chkd("rd_rdata", r_rdata, 36'o777000000001);
    chkb("rd_nxm", r_nxm, 1'b0);
    ebus.ebusDataIn = 36'o555555555555;
    tick();
    tick();
    chkd("rd_rdata_hold", rdata, 36'o777000000001);

    // Read timeout, no device
    run(1'b1, 7'o55, 3'o1, 36'o0, 0, -1, 0, 36'o0);
    chki("to_demand_cycles", r_dem, 64);
    chki("to_done_cyc", r_done, 68);
    chkb("to_nxm", r_nxm, 1'b1);
    chkd("to_rdata_zero", r_rdata, '0);
    tick();
    chkb("to_nxm_hold", nxm, 1'b1);

    // Xfer lands in the last timeout cycle: transfer wins
    run(1'b1, 7'o55, 3'o1, 36'o0, 0, 64, 1, 36'o525252525252);
    chkb("bd_nxm_cleared_on_accept", r_nxm0, 1'b0);
    chki("bd_demand_cycles", r_dem, 64);
    chkb("bd_nxm", r_nxm, 1'b0);
    chkd("bd_rdata", r_rdata, 36'o525252525252);

    // Device holds xfer 5 cycles
    run(1'b0, 7'o3, 3'o7, 36'o707070707070, 0, 1, 5, 36'o0);
    chki("hold_release", r_rel, 5);
    chki("hold_done_cyc", r_done, 9);
    chki("hold_drvdata_bad", r_bad, 0);

    // Grant withheld 10 cycles
    run(1'b0, 7'o41, 3'o5, 36'o1, 10, 1, 1, 36'o0);
    chki("gnt_req_no_cs", r_reqonly, 11);
    chki("gnt_req_gaps", r_gap, 0);
    chki("gnt_done_cyc", r_done, 15);

    // start while busy is ignored
    ebus.ebusGrant = 1'b1;
    start  = 1'b1;
    isRead = 1'b0;
    cs     = 7'o11;
    fcn    = 3'o3;
    wdata  = 36'o444444444444;
    tick();
    isRead = 1'b1;
    cs     = 7'o66;
    wdata  = 36'o222222222222;
    tick();
    start = 1'b0;
    chkd("busy_cs", {29'd0, ebus.ebusCS}, {29'd0, 7'o11});
    chkb("busy_drv", ebus.drvDriving, 1'b1);
    chkd("busy_drvdata", ebus.drvData, 36'o444444444444);
    tick();
    tick();
    ebus.ebusXfer = 1'b1;
    tick();
    ebus.ebusXfer = 1'b0;
    chkd("busy_cs_release", {29'd0, ebus.ebusCS}, {29'd0, 7'o11});
    tick();
    chkb("busy_done", done, 1'b1);
    tick();
    chkb("busy_ready", ready, 1'b1);

    // Reset in DEMAND
    start  = 1'b1;
    isRead = 1'b0;
    cs     = 7'o17;
    fcn    = 3'o6;
    wdata  = 36'o765432107654;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chkb("crb_in_demand", ebus.ebusDemand, 1'b1);
    CROBAR = 1'b1;
    tick();
    chkb("crb_ready", ready, 1'b1);
    chkb("crb_req_dem", ebus.ebusReq | ebus.ebusDemand, 1'b0);
    chki("crb_cs_fcn", int'({ebus.ebusCS, ebus.ebusFCN}), 0);
    chkd("crb_drvdata", ebus.drvData, '0);
    chkb("crb_drv_done", ebus.drvDriving | done, 1'b0);
    CROBAR = 1'b0;
    tick();
    chkb("crb_no_done", done, 1'b0);
    chkb("crb_ready_after", ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ebus_xfer_ctl.md
Name: ebus_xfer_ctl

Overview:
- EBOX-side EBUS transfer sequencer for I/O instructions (CONO/CONI/DATAO/DATAI) to controllers on EBUS (RH20, DTE20 and similar).
- Requests the bus, drives controller-select, function and write data, then asserts demand and waits for the device's transfer response. On a read it captures the EBUS data, then releases the bus.
- Its write-data output is one more EBUSdriver source feeding the top-level EBUS data mux. Its read input is the muxed EBUS data.

Parameters:
- SETUP_CYCLES, 2: cycles that CS, FCN and data are held stable before demand asserts (minimum 1).
- TIMEOUT_CYCLES, 64: cycles in DEMAND with no transfer before a non-existent-device abort.
- CNT_W, 8: width of the shared setup/timeout counter. Must satisfy 2**CNT_W > max(SETUP_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- CROBAR  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request pulse. Accepted only when ready=1.
- isRead  in  1  1 = CONI/DATAI, 0 = CONO/DATAO. Sampled with start.
- cs  in  [0:6]  controller select. Sampled with start.
- fcn  in  [0:2]  EBUS function code. Sampled with start.
- wdata  in  [0:35]  write data. Sampled with start.
- ebusGrant  in  1  bus grant from the EBUS arbiter.
- ebusXfer  in  1  device transfer acknowledge.
- ebusDataIn  in  [0:35]  muxed EBUS data.
- ebusReq  out  1  bus request to the arbiter.
- ebusCS  out  [0:6]  driven controller select. Zero when not owning the bus.
- ebusFCN  out  [0:2]  driven function code. Zero when not owning the bus.
- ebusDemand  out  1  demand strobe.
- drvDriving  out  1  EBUSdriver.driving for the data mux.
- drvData  out  [0:35]  EBUSdriver.data. Zero when drvDriving=0.
- ready  out  1  idle and able to accept start.
- done  out  1  one-cycle completion pulse.
- nxm  out  1  valid with done: the transfer timed out.
- rdata  out  [0:35]  read result. Held until the next accepted start.

Behaviour:
- Reset: state=IDLE, ready=1. ebusReq, ebusCS, ebusFCN, ebusDemand, drvDriving, drvData, done, nxm and rdata are all 0. Reset asserted in any state returns to IDLE on that edge and all bus outputs drop; no done is produced.
- States and transitions:
  - IDLE: ready=1. On start, latch isRead/cs/fcn/wdata and go to REQ. start while ready=0 is ignored with no side effects.
  - REQ: ebusReq=1. Stay until ebusGrant=1, then go to SETUP and clear the counter.
  - SETUP: ebusReq=1. ebusCS and ebusFCN are driven. drvDriving = ~isRead and drvData = wdata on writes. The counter increments each cycle. When count == SETUP_CYCLES-1, go to DEMAND and clear the counter.
  - DEMAND: all SETUP outputs held, plus ebusDemand=1.
    - ebusXfer=1: on a read, rdata <= ebusDataIn, nxm <= 0; go to RELEASE.
    - Else if count == TIMEOUT_CYCLES-1: nxm <= 1, rdata <= 0 on a read; go to RELEASE.
    - Else increment the counter.
    - ebusXfer and timeout in the same cycle: the transfer wins, nxm=0.
  - RELEASE: ebusDemand=0 and drvDriving=0; CS, FCN and ebusReq held. When ebusXfer=0, go to DONE. A device holding xfer high keeps the block in RELEASE indefinitely (no second timeout).
  - DONE: done=1 for exactly one cycle. ebusReq, CS and FCN drop. Go to IDLE. ready returns the cycle after done.
- ebusGrant is only sampled in REQ; its deassertion after the grant is ignored.
- Latency, no wait states (grant in the first REQ cycle, xfer in the first DEMAND cycle, xfer low the next cycle): start accepted at cycle 0, done at cycle 3+SETUP_CYCLES.
- nxm and rdata are stable from the done cycle until the next accepted start. nxm clears on accept.

Test Plan:
- Write: start with isRead=0, cs=7'o24, fcn=3'o4, wdata=36'o123456701234; grant immediately; xfer 1 cycle after demand -> drvData=123456701234 and drvDriving=1 through SETUP+DEMAND; demand high 2 cycles; done at cycle 6 (SETUP_CYCLES=2), nxm=0.
- Read: isRead=1, ebusDataIn=36'o777000000001 during xfer -> drvDriving never 1; rdata=777000000001 at done; rdata holds after ebusDataIn changes.
- Timeout: no xfer -> demand high exactly 64 cycles; done with nxm=1; rdata=0 on a read.
- Boundary: xfer asserted in the 64th DEMAND cycle -> nxm=0, data captured. Device holds xfer 5 cycles -> RELEASE lasts 5 cycles, then done.
- Grant delay and reset: grant withheld 10 cycles -> ebusReq held, no CS driven. CROBAR during DEMAND -> all outputs 0 next edge, ready=1, no done. start while busy -> ignored, latched values unchanged.
